// File: rtl/aes_stream_ctrl.sv
// Streaming valid/ready shell around the non-stallable aes_128 pipeline.
// Credits cover in-flight plus buffered blocks, so retiring ciphertexts always find FIFO space.
module aes_stream_ctrl #(
    parameter int LATENCY    = 21,
    parameter int FIFO_DEPTH = 32,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_state,
    input  logic [127:0]     in_key,
    output logic [127:0]     core_state,
    output logic [127:0]     core_key,
    input  logic [127:0]     core_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [CNT_W-1:0] inflight,
    output logic [CNT_W-1:0] fifo_count
);
    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W:0]   CREDITS  = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic               acc;
    logic               ret;
    logic               pop;
    logic [LATENCY-1:0] vld;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W:0]     credit_used;
    logic [127:0]       mem [FIFO_DEPTH];

    // Credits come from registered counts only, so in_ready never depends on in_valid.
    assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
    assign in_ready    = !rst && (credit_used < CREDITS);
    assign acc         = in_valid && in_ready;

    assign core_state  = acc ? in_state : '0;
    assign core_key    = acc ? in_key   : '0;

    assign ret         = vld[LATENCY-1];
    assign out_valid   = (fifo_count != '0);
    assign pop         = out_valid && out_ready;
    assign out_data    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld        <= '0;
            inflight   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            vld <= (vld << 1) | LATENCY'(acc);

            case ({acc, ret})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: ;
            endcase

            case ({ret, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: ;
            endcase

            if (ret) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

            // The core cannot stall, so a retire into a full FIFO would lose a block.
            if (ret) assert (fifo_count != FULL_CNT);
        end
    end

    // Storage is deliberately not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (ret && !rst) mem[wr_ptr] <= core_out;
    end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Bench for aes_stream_ctrl: a stub aes_128 pipeline returns known-answer ciphertexts,
// a negedge monitor pops a scoreboard queue filled at each accepted handshake.
module tb_aes_stream_ctrl;
    localparam int L   = 21;
    localparam int D   = 32;
    localparam int CW  = 6;
    localparam int D4  = 4;
    localparam int CW4 = 5;

    localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] MIX  = 128'ha5a5a5a55a5a5a5ac3c3c3c33c3c3c3c;
    localparam logic [127:0] K_T  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Known answers for the two FIPS-197 vectors; any other input gets a cheap unique tag.
    function automatic logic [127:0] aes_ref(input logic [127:0] st, input logic [127:0] key);
        if (st == P_C1 && key == K_C1) return C_C1;
        if (st == P_B  && key == K_B)  return C_B;
        return st ^ {key[63:0], key[127:64]} ^ MIX;
    endfunction

    function automatic logic [127:0] vec_st(input int mode, input int idx);
        if (mode == 1) return (idx % 2 == 0) ? P_C1 : P_B;
        return {32'hdeadbeef, 32'h00c0ffee, 32'h12345678, idx};
    endfunction

    function automatic logic [127:0] vec_key(input int mode, input int idx);
        if (mode == 1) return (idx % 2 == 0) ? K_C1 : K_B;
        return K_T;
    endfunction

    // ---------------- DUT A: default parameters ----------------
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [127:0]  in_state = '0;
    logic [127:0]  in_key   = '0;
    logic [127:0]  core_state, core_key, core_out;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [127:0]  out_data;
    logic [CW-1:0] inflight, fifo_count;

    aes_stream_ctrl #(.LATENCY(L), .FIFO_DEPTH(D), .CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_key(in_key),
        .core_state(core_state), .core_key(core_key), .core_out(core_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .inflight(inflight), .fifo_count(fifo_count)
    );

    logic [127:0] pa [L];
    always @(posedge clk) begin
        pa[0] <= aes_ref(core_state, core_key);
        for (int k = 1; k < L; k++) pa[k] <= pa[k-1];
    end
    assign core_out = pa[L-1];

    // ---------------- DUT B: shallow FIFO, credit-limited ----------------
    logic           b_in_valid = 1'b0;
    logic           b_in_ready;
    logic [127:0]   b_in_state = '0;
    logic [127:0]   b_in_key   = '0;
    logic [127:0]   b_core_state, b_core_key, b_core_out;
    logic           b_out_valid;
    logic           b_out_ready = 1'b1;
    logic [127:0]   b_out_data;
    logic [CW4-1:0] b_inflight, b_fifo_count;

    aes_stream_ctrl #(.LATENCY(L), .FIFO_DEPTH(D4), .CNT_W(CW4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_state(b_in_state), .in_key(b_in_key),
        .core_state(b_core_state), .core_key(b_core_key), .core_out(b_core_out),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .inflight(b_inflight), .fifo_count(b_fifo_count)
    );

    logic [127:0] pb [L];
    always @(posedge clk) begin
        pb[0] <= aes_ref(b_core_state, b_core_key);
        for (int k = 1; k < L; k++) pb[k] <= pb[k-1];
    end
    assign b_core_out = pb[L-1];

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    logic [127:0] qa [$];
    logic [127:0] exp_a;
    logic         acc_a = 1'b0;
    int acc_a_cnt = 0, pop_a_cnt = 0, stall_a = 0, core_bad = 0;

    always @(negedge clk) begin
        acc_a = !rst && in_valid && in_ready;
        if (rst) qa.delete();
        if (acc_a) begin
            qa.push_back(aes_ref(in_state, in_key));
            acc_a_cnt++;
        end
        if (!rst && in_valid && !in_ready) stall_a++;
        if ((acc_a && (core_state !== in_state || core_key !== in_key)) ||
            (!acc_a && (core_state !== '0 || core_key !== '0))) core_bad++;
        if (!rst && out_valid && out_ready) begin
            pop_a_cnt++;
            if (qa.size() == 0) check("a_out_while_queue_empty", 0, 1);
            else begin
                exp_a = qa.pop_front();
                check("a_out_data", out_data, exp_a);
            end
        end
    end

    logic [127:0] qb [$];
    logic [127:0] exp_b;
    logic         b_acc = 1'b0;
    bit b_on = 0;
    int b_idx = 0, b_acc_cnt = 0, b_pop_cnt = 0, b_stall = 0, b_over = 0, b_max = 0, b_sum;

    always @(negedge clk) begin
        b_acc = !rst && b_in_valid && b_in_ready;
        if (rst) qb.delete();
        if (b_acc) begin
            qb.push_back(aes_ref(b_in_state, b_in_key));
            b_acc_cnt++;
        end
        b_sum = int'(b_inflight) + int'(b_fifo_count);
        if (b_sum > D4) b_over++;
        if (b_sum > b_max) b_max = b_sum;
        if (!rst && b_in_valid && !b_in_ready) b_stall++;
        if (!rst && b_out_valid && b_out_ready) begin
            b_pop_cnt++;
            if (qb.size() == 0) check("b_out_while_queue_empty", 0, 1);
            else begin
                exp_b = qb.pop_front();
                check("b_out_data", b_out_data, exp_b);
            end
        end
    end

    // ---------------- drivers ----------------
    bit src_on = 0;
    int src_mode = 1, src_idx = 0;

    always @(posedge clk) begin
        #1;
        if (acc_a) src_idx++;
        in_valid = src_on;
        in_state = vec_st(src_mode, src_idx);
        in_key   = vec_key(src_mode, src_idx);
    end

    always @(posedge clk) begin
        #1;
        if (b_acc) b_idx++;
        b_in_valid = b_on;
        b_in_state = vec_st(2, b_idx + 1000);
        b_in_key   = vec_key(2, b_idx + 1000);
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    // out_ready moves just after a posedge so the negedge monitor sees every pop.
    task automatic set_ready(input logic v);
        @(posedge clk); #1;
        out_ready = v;
        step();
    endtask

    task automatic send_n(input int mode, input int n, input int budget);
        int base = acc_a_cnt;
        int t = 0;
        src_mode = mode;
        src_idx  = 0;
        src_on   = 1;
        while (acc_a_cnt - base < n && t < budget) begin
            step();
            t++;
        end
        src_on = 0;
        check("send_n_accepts", acc_a_cnt - base, n);
    endtask

    task automatic single_c1(input string tag);
        int t0, t;
        send_n(1, 1, 20);
        t0 = cyc;
        t = 0;
        while (!out_valid && t < 100) begin
            step();
            t++;
        end
        check({tag, "_latency"}, cyc - t0, L + 1);
        check({tag, "_data"}, out_data, C_C1);
        step();
        check({tag, "_one_beat"}, out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int base, base_pop, base_stall, t, vcnt, t0;
        logic ok;

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_inflight", inflight, 0);
        check("rst_fifo_count", fifo_count, 0);
        rst = 1'b0;
        step();
        check("post_rst_in_ready", in_ready, 1);

        // Single FIPS-197 C.1 block
        single_c1("c1");

        // Back-to-back alternating vectors
        base_pop   = pop_a_cnt;
        base_stall = stall_a;
        vcnt = 0;
        fork
            send_n(1, 64, 200);
            begin
                t = 0;
                while (!out_valid && t < 200) begin
                    step();
                    t++;
                end
                for (int j = 0; j < 64; j++) begin
                    if (out_valid) vcnt++;
                    step();
                end
                check("b2b_valid_end", out_valid, 0);
            end
        join
        check("b2b_valid_run", vcnt, 64);
        check("b2b_no_stall", stall_a - base_stall, 0);
        check("b2b_pops", pop_a_cnt - base_pop, 64);
        check("b2b_queue_empty", qa.size(), 0);

        // Backpressure up to full credit, then release
        set_ready(0);
        base     = acc_a_cnt;
        base_pop = pop_a_cnt;
        src_mode = 2;
        src_idx  = 0;
        src_on   = 1;
        repeat (40) step();
        check("bp_credit_sum", int'(inflight) + int'(fifo_count), D);
        check("bp_in_ready_low", in_ready, 0);
        repeat (40) step();
        check("bp_accepts", acc_a_cnt - base, D);
        check("bp_fifo_full", fifo_count, D);
        check("bp_inflight_zero", inflight, 0);
        set_ready(1);
        t = 0;
        while (acc_a_cnt - base <= D && t < 10) begin
            step();
            t++;
        end
        ok = (acc_a_cnt - base > D);
        check("bp_accepts_resume", ok, 1);
        src_on = 0;
        t = 0;
        while (!(qa.size() == 0 && fifo_count == 0 && inflight == 0) && t < 300) begin
            step();
            t++;
        end
        ok = (qa.size() == 0 && fifo_count == 0 && inflight == 0);
        check("bp_drained", ok, 1);
        check("bp_pops_match", pop_a_cnt - base_pop, acc_a_cnt - base);

        // Pop and write on the same edge with one entry buffered
        set_ready(0);
        send_n(2, 2, 20);
        t0 = cyc;
        do begin
            @(posedge clk); #1;
        end while (cyc < t0 + L);
        out_ready = 1'b1;
        step();
        check("pw_count_before", fifo_count, 1);
        check("pw_inflight_before", inflight, 1);
        step();
        check("pw_count_after", fifo_count, 1);
        check("pw_head_is_new", out_data, aes_ref(vec_st(2, 1), vec_key(2, 1)));
        check("pw_inflight_after", inflight, 0);
        step();
        check("pw_empty", out_valid, 0);

        // Shallow FIFO: credits cap in-flight + buffered at 4, nothing lost
        b_on = 1;
        repeat (200) step();
        b_on = 0;
        repeat (60) step();
        check("d4_never_over_credit", b_over, 0);
        check("d4_max_credit_used", b_max, D4);
        ok = (b_stall > 0);
        check("d4_in_ready_dropped", ok, 1);
        ok = (b_acc_cnt >= 8);
        check("d4_enough_accepts", ok, 1);
        check("d4_pops_match", b_pop_cnt, b_acc_cnt);
        check("d4_queue_empty", qb.size(), 0);

        // Reset with 10 in flight and 5 buffered
        set_ready(0);
        send_n(2, 15, 40);
        t = 0;
        while (fifo_count != 5 && t < 60) begin
            step();
            t++;
        end
        check("mid_fifo_count", fifo_count, 5);
        check("mid_inflight", inflight, 10);
        rst = 1'b1;
        step();
        check("mrst_out_valid", out_valid, 0);
        check("mrst_inflight", inflight, 0);
        check("mrst_fifo_count", fifo_count, 0);
        check("mrst_in_ready", in_ready, 0);
        step();
        rst = 1'b0;
        #1;
        check("mrst_in_ready_after", in_ready, 1);
        set_ready(1);
        base_pop = pop_a_cnt;
        repeat (40) step();
        check("mrst_no_stale_out", pop_a_cnt - base_pop, 0);
        single_c1("post_rst_c1");

        check("core_inputs_gated", core_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
